// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared widths, ID/EX payload type and source-match helper
package rv32i_pkg;

    localparam int REGIDX_WIDTH = 5;
    localparam int CTRL_WIDTH   = 16;

    typedef struct packed {
        logic [31:0]             rs1_data;
        logic [31:0]             rs2_data;
        logic [REGIDX_WIDTH-1:0] rd_addr;
        logic                    rd_wen;
        logic                    is_load;
        logic [31:0]             pc;
        logic [31:0]             imm;
        logic [CTRL_WIDTH-1:0]   ctrl;
    } id_ex_t;

    // x0 never matches, so it can never forward or create a hazard
    function automatic logic src_match(
        input logic                    valid,
        input logic                    wen,
        input logic [REGIDX_WIDTH-1:0] rd_addr,
        input logic [REGIDX_WIDTH-1:0] rs_addr,
        input logic                    rs_used
    );
        return valid & wen & (rd_addr == rs_addr) & (rs_addr != '0) & rs_used;
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// rtl/operand_bypass.sv - one source operand: match, priority select, stall need
module operand_bypass
    import rv32i_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REGIDX_WIDTH-1:0] i_rs_addr,
    input  logic                    i_rs_used,
    input  logic [31:0]             i_rf_data,
    input  logic                    i_ex_valid,
    input  logic                    i_ex_rd_wen,
    input  logic [REGIDX_WIDTH-1:0] i_ex_rd_addr,
    input  logic                    i_ex_data_ok,
    input  logic [31:0]             i_ex_rd_data,
    input  logic                    i_mem_valid,
    input  logic                    i_mem_rd_wen,
    input  logic [REGIDX_WIDTH-1:0] i_mem_rd_addr,
    input  logic                    i_mem_data_ok,
    input  logic [31:0]             i_mem_rd_data,
    input  logic                    i_wb_valid,
    input  logic                    i_wb_rd_wen,
    input  logic [REGIDX_WIDTH-1:0] i_wb_rd_addr,
    input  logic                    i_wb_data_ok,
    input  logic [31:0]             i_wb_rd_data,
    output logic [31:0]             o_data,
    output logic                    o_stall
);

    logic m_ex, m_mem, m_wb;

    assign m_ex  = src_match(i_ex_valid,  i_ex_rd_wen,  i_ex_rd_addr,  i_rs_addr, i_rs_used);
    assign m_mem = src_match(i_mem_valid, i_mem_rd_wen, i_mem_rd_addr, i_rs_addr, i_rs_used);
    assign m_wb  = src_match(i_wb_valid,  i_wb_rd_wen,  i_wb_rd_addr,  i_rs_addr, i_rs_used);

    // Only the youngest producer counts; an older one's data_ok is irrelevant
    always_comb begin
        o_data  = i_rf_data;
        o_stall = 1'b0;
        if (i_rs_addr == '0) begin
            o_data = 32'h0;
        end else if (m_ex) begin
            o_data  = i_ex_rd_data;
            o_stall = ~i_ex_data_ok;
        end else if (m_mem) begin
            o_data  = i_mem_rd_data;
            o_stall = ~i_mem_data_ok;
        end else if (m_wb) begin
            o_data  = i_wb_rd_data;
            o_stall = ~i_wb_data_ok;
        end
        if (!FWD_EN && (m_ex || m_mem || m_wb)) begin
            o_stall = 1'b1;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - operand fetch/bypass and the ID/EX pipeline register
module id_operand_stage
    import rv32i_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_id_valid,
    input  logic [REGIDX_WIDTH-1:0] i_id_rs1_addr,
    input  logic [REGIDX_WIDTH-1:0] i_id_rs2_addr,
    input  logic                    i_id_rs1_used,
    input  logic                    i_id_rs2_used,
    input  logic [REGIDX_WIDTH-1:0] i_id_rd_addr,
    input  logic                    i_id_rd_wen,
    input  logic                    i_id_is_load,
    input  logic [31:0]             i_id_pc,
    input  logic [31:0]             i_id_imm,
    input  logic [CTRL_WIDTH-1:0]   i_id_ctrl,
    output logic                    o_id_ready,
    output logic [REGIDX_WIDTH-1:0] o_rf_rs1_addr,
    output logic [REGIDX_WIDTH-1:0] o_rf_rs2_addr,
    input  logic [31:0]             i_rf_rs1_data,
    input  logic [31:0]             i_rf_rs2_data,
    input  logic                    i_ex_valid,
    input  logic                    i_ex_rd_wen,
    input  logic [REGIDX_WIDTH-1:0] i_ex_rd_addr,
    input  logic                    i_ex_data_ok,
    input  logic [31:0]             i_ex_rd_data,
    input  logic                    i_mem_valid,
    input  logic                    i_mem_rd_wen,
    input  logic [REGIDX_WIDTH-1:0] i_mem_rd_addr,
    input  logic                    i_mem_data_ok,
    input  logic [31:0]             i_mem_rd_data,
    input  logic                    i_wb_valid,
    input  logic                    i_wb_rd_wen,
    input  logic [REGIDX_WIDTH-1:0] i_wb_rd_addr,
    input  logic                    i_wb_data_ok,
    input  logic [31:0]             i_wb_rd_data,
    input  logic                    i_flush,
    input  logic                    i_ex_ready,
    output logic                    o_ex_valid,
    output logic [31:0]             o_ex_rs1_data,
    output logic [31:0]             o_ex_rs2_data,
    output logic [REGIDX_WIDTH-1:0] o_ex_rd_addr,
    output logic                    o_ex_rd_wen,
    output logic                    o_ex_is_load,
    output logic [31:0]             o_ex_pc,
    output logic [31:0]             o_ex_imm,
    output logic [CTRL_WIDTH-1:0]   o_ex_ctrl
);

    logic [31:0] rs1_data, rs2_data;
    logic        rs1_stall, rs2_stall;
    logic        hazard, accept;
    logic        ex_valid_q, ex_valid_d;
    id_ex_t      ex_q, ex_d;

    assign o_rf_rs1_addr = i_id_rs1_addr;
    assign o_rf_rs2_addr = i_id_rs2_addr;

    operand_bypass #(.FWD_EN(FWD_EN)) u_rs1 (
        .i_rs_addr(i_id_rs1_addr), .i_rs_used(i_id_rs1_used), .i_rf_data(i_rf_rs1_data),
        .i_ex_valid(i_ex_valid), .i_ex_rd_wen(i_ex_rd_wen), .i_ex_rd_addr(i_ex_rd_addr),
        .i_ex_data_ok(i_ex_data_ok), .i_ex_rd_data(i_ex_rd_data),
        .i_mem_valid(i_mem_valid), .i_mem_rd_wen(i_mem_rd_wen), .i_mem_rd_addr(i_mem_rd_addr),
        .i_mem_data_ok(i_mem_data_ok), .i_mem_rd_data(i_mem_rd_data),
        .i_wb_valid(i_wb_valid), .i_wb_rd_wen(i_wb_rd_wen), .i_wb_rd_addr(i_wb_rd_addr),
        .i_wb_data_ok(i_wb_data_ok), .i_wb_rd_data(i_wb_rd_data),
        .o_data(rs1_data), .o_stall(rs1_stall)
    );

    operand_bypass #(.FWD_EN(FWD_EN)) u_rs2 (
        .i_rs_addr(i_id_rs2_addr), .i_rs_used(i_id_rs2_used), .i_rf_data(i_rf_rs2_data),
        .i_ex_valid(i_ex_valid), .i_ex_rd_wen(i_ex_rd_wen), .i_ex_rd_addr(i_ex_rd_addr),
        .i_ex_data_ok(i_ex_data_ok), .i_ex_rd_data(i_ex_rd_data),
        .i_mem_valid(i_mem_valid), .i_mem_rd_wen(i_mem_rd_wen), .i_mem_rd_addr(i_mem_rd_addr),
        .i_mem_data_ok(i_mem_data_ok), .i_mem_rd_data(i_mem_rd_data),
        .i_wb_valid(i_wb_valid), .i_wb_rd_wen(i_wb_rd_wen), .i_wb_rd_addr(i_wb_rd_addr),
        .i_wb_data_ok(i_wb_data_ok), .i_wb_rd_data(i_wb_rd_data),
        .o_data(rs2_data), .o_stall(rs2_stall)
    );

    assign hazard     = i_id_valid & (rs1_stall | rs2_stall);
    assign o_id_ready = ~i_rst & ~i_flush & ~hazard & (~ex_valid_q | i_ex_ready);
    assign accept     = i_id_valid & o_id_ready;

    // Payload is left untouched on bubbles and flushes; only valid matters then
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (i_flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            ex_d       = '{rs1_data: rs1_data, rs2_data: rs2_data, rd_addr: i_id_rd_addr,
                           rd_wen: i_id_rd_wen, is_load: i_id_is_load, pc: i_id_pc,
                           imm: i_id_imm, ctrl: i_id_ctrl};
        end else if (!ex_valid_q || i_ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    assign o_ex_valid    = ex_valid_q;
    assign o_ex_rs1_data = ex_q.rs1_data;
    assign o_ex_rs2_data = ex_q.rs2_data;
    assign o_ex_rd_addr  = ex_q.rd_addr;
    assign o_ex_rd_wen   = ex_q.rd_wen;
    assign o_ex_is_load  = ex_q.is_load;
    assign o_ex_pc       = ex_q.pc;
    assign o_ex_imm      = ex_q.imm;
    assign o_ex_ctrl     = ex_q.ctrl;

endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - directed scoreboard bench for id_operand_stage
module tb_id_operand_stage;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, id_valid, rs1_used, rs2_used, rd_wen, is_load, flush, ex_ready;
    logic [REGIDX_WIDTH-1:0] rs1, rs2, rd;
    logic [31:0]             pc, imm;
    logic [CTRL_WIDTH-1:0]   ctrl;
    logic                    exv, ex_wen, ex_ok, memv, mem_wen, mem_ok, wbv, wb_wen, wb_ok;
    logic [REGIDX_WIDTH-1:0] ex_rd, mem_rd, wb_rd;
    logic [31:0]             ex_d, mem_d, wb_d;

    logic                    ready, o_valid, ready0, o_valid0;
    logic [REGIDX_WIDTH-1:0] ra1, ra2, ra1_0, ra2_0, o_rd, o_rd0;
    logic [31:0]             o_r1, o_r2, o_pc, o_imm, o_r1_0, o_r2_0, o_pc0, o_imm0;
    logic                    o_wen, o_ld, o_wen0, o_ld0;
    logic [CTRL_WIDTH-1:0]   o_ctrl, o_ctrl0;
    id_ex_t                  obs, obs0;

    function automatic logic [31:0] rf(input logic [REGIDX_WIDTH-1:0] a);
        return {16'hC0DE, 11'h0, a};
    endfunction

    id_operand_stage #(.FWD_EN(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
        .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
        .i_id_rd_addr(rd), .i_id_rd_wen(rd_wen), .i_id_is_load(is_load),
        .i_id_pc(pc), .i_id_imm(imm), .i_id_ctrl(ctrl), .o_id_ready(ready),
        .o_rf_rs1_addr(ra1), .o_rf_rs2_addr(ra2), .i_rf_rs1_data(rf(ra1)), .i_rf_rs2_data(rf(ra2)),
        .i_ex_valid(exv), .i_ex_rd_wen(ex_wen), .i_ex_rd_addr(ex_rd), .i_ex_data_ok(ex_ok), .i_ex_rd_data(ex_d),
        .i_mem_valid(memv), .i_mem_rd_wen(mem_wen), .i_mem_rd_addr(mem_rd), .i_mem_data_ok(mem_ok), .i_mem_rd_data(mem_d),
        .i_wb_valid(wbv), .i_wb_rd_wen(wb_wen), .i_wb_rd_addr(wb_rd), .i_wb_data_ok(wb_ok), .i_wb_rd_data(wb_d),
        .i_flush(flush), .i_ex_ready(ex_ready), .o_ex_valid(o_valid),
        .o_ex_rs1_data(o_r1), .o_ex_rs2_data(o_r2), .o_ex_rd_addr(o_rd), .o_ex_rd_wen(o_wen),
        .o_ex_is_load(o_ld), .o_ex_pc(o_pc), .o_ex_imm(o_imm), .o_ex_ctrl(o_ctrl)
    );

    id_operand_stage #(.FWD_EN(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
        .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
        .i_id_rd_addr(rd), .i_id_rd_wen(rd_wen), .i_id_is_load(is_load),
        .i_id_pc(pc), .i_id_imm(imm), .i_id_ctrl(ctrl), .o_id_ready(ready0),
        .o_rf_rs1_addr(ra1_0), .o_rf_rs2_addr(ra2_0), .i_rf_rs1_data(rf(ra1_0)), .i_rf_rs2_data(rf(ra2_0)),
        .i_ex_valid(exv), .i_ex_rd_wen(ex_wen), .i_ex_rd_addr(ex_rd), .i_ex_data_ok(ex_ok), .i_ex_rd_data(ex_d),
        .i_mem_valid(memv), .i_mem_rd_wen(mem_wen), .i_mem_rd_addr(mem_rd), .i_mem_data_ok(mem_ok), .i_mem_rd_data(mem_d),
        .i_wb_valid(wbv), .i_wb_rd_wen(wb_wen), .i_wb_rd_addr(wb_rd), .i_wb_data_ok(wb_ok), .i_wb_rd_data(wb_d),
        .i_flush(flush), .i_ex_ready(ex_ready), .o_ex_valid(o_valid0),
        .o_ex_rs1_data(o_r1_0), .o_ex_rs2_data(o_r2_0), .o_ex_rd_addr(o_rd0), .o_ex_rd_wen(o_wen0),
        .o_ex_is_load(o_ld0), .o_ex_pc(o_pc0), .o_ex_imm(o_imm0), .o_ex_ctrl(o_ctrl0)
    );

    assign obs  = {o_r1, o_r2, o_rd, o_wen, o_ld, o_pc, o_imm, o_ctrl};
    assign obs0 = {o_r1_0, o_r2_0, o_rd0, o_wen0, o_ld0, o_pc0, o_imm0, o_ctrl0};

    int     n_cmp  = 0;
    int     n_fail = 0;
    id_ex_t sb_q[$];

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic id_ex_t mk(input logic [31:0] a, input logic [31:0] b);
        return '{rs1_data: a, rs2_data: b, rd_addr: rd, rd_wen: rd_wen, is_load: is_load,
                 pc: pc, imm: imm, ctrl: ctrl};
    endfunction

    task automatic set_id(input logic [REGIDX_WIDTH-1:0] a1, input logic u1,
                          input logic [REGIDX_WIDTH-1:0] a2, input logic u2, input logic [31:0] p);
        id_valid = 1'b1; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
        rd = 5'd20; rd_wen = 1'b1; is_load = p[2]; pc = p; imm = ~p; ctrl = p[15:0] ^ 16'h5A5A;
    endtask

    task automatic clr_src();
        exv = 0; ex_wen = 0; ex_rd = 0; ex_ok = 0; ex_d = 0;
        memv = 0; mem_wen = 0; mem_rd = 0; mem_ok = 0; mem_d = 0;
        wbv = 0; wb_wen = 0; wb_rd = 0; wb_ok = 0; wb_d = 0;
    endtask

    // Model ID/EX occupancy: consumer pops on ex_ready, accept pushes, flush/reset empty it
    task automatic cycle(input bit acc, input id_ex_t exp, input string tag);
        if (rst || flush) sb_q.delete();
        else begin
            if (ex_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (acc) sb_q.push_back(exp);
        end
        @(posedge clk); #1;
        if (sb_q.size() == 0) check({tag, "/valid"}, 160'(o_valid), 160'(1'b0));
        else begin
            check({tag, "/valid"}, 160'(o_valid), 160'(1'b1));
            check({tag, "/payload"}, 160'(obs), 160'(sb_q[0]));
        end
    endtask

    initial begin
        rst = 1; flush = 0; ex_ready = 1; clr_src();
        set_id(5'd1, 1, 5'd2, 1, 32'h10);
        #1;
        check("rst/ready", 160'(ready), 160'(1'b0));
        check("rst/ready0", 160'(ready0), 160'(1'b0));
        cycle(0, '0, "rst");
        check("rst/payload_zero", 160'(obs), 160'(0));
        cycle(0, '0, "rst2");
        rst = 0;

        // ex beats mem
        set_id(5'd5, 1, 5'd6, 1, 32'h100);
        exv = 1; ex_wen = 1; ex_rd = 5'd5; ex_ok = 1; ex_d = 32'hDEAD_BEEF;
        memv = 1; mem_wen = 1; mem_rd = 5'd5; mem_ok = 1; mem_d = 32'h1;
        #1 check("fwd_ex/ready", 160'(ready), 160'(1'b1));
        cycle(1, mk(32'hDEAD_BEEF, rf(6)), "fwd_ex");

        // x0 ignores producers
        clr_src(); set_id(5'd9, 1, 5'd0, 1, 32'h104);
        exv = 1; ex_wen = 1; ex_ok = 1; ex_d = '1;
        memv = 1; mem_wen = 1; mem_ok = 1; mem_d = '1;
        wbv = 1; wb_wen = 1; wb_ok = 1; wb_d = '1;
        #1 check("x0/ready", 160'(ready), 160'(1'b1));
        cycle(1, mk(rf(9), 32'h0), "x0");

        // mem beats wb; unused operand ignores a matching producer
        clr_src(); set_id(5'd4, 1, 5'd4, 0, 32'h108);
        memv = 1; mem_wen = 1; mem_rd = 5'd4; mem_ok = 1; mem_d = 32'h44;
        wbv = 1; wb_wen = 1; wb_rd = 5'd4; wb_ok = 1; wb_d = 32'h55;
        #1 cycle(1, mk(32'h44, rf(4)), "mem_wb");

        // older not-ok producer shadowed by ready ex result
        mem_ok = 0; exv = 1; ex_wen = 1; ex_rd = 5'd4; ex_ok = 1; ex_d = 32'h77;
        set_id(5'd4, 1, 5'd4, 1, 32'h10C);
        #1 check("shadow/ready", 160'(ready), 160'(1'b1));
        cycle(1, mk(32'h77, 32'h77), "shadow");

        // load-use stall then forward from mem
        clr_src(); set_id(5'd7, 1, 5'd0, 0, 32'h200);
        exv = 1; ex_wen = 1; ex_rd = 5'd7; ex_ok = 0; ex_d = 32'hBAD;
        #1 check("load/ready0", 160'(ready), 160'(1'b0));
        cycle(0, '0, "load_bubble");
        clr_src(); memv = 1; mem_wen = 1; mem_rd = 5'd7; mem_ok = 1; mem_d = 32'h1234;
        #1 check("load/ready1", 160'(ready), 160'(1'b1));
        cycle(1, mk(32'h1234, 32'h0), "load_fwd");

        // hold for three cycles while wb writes the held operand's register
        clr_src(); set_id(5'd3, 1, 5'd0, 1, 32'h400);
        cycle(1, mk(rf(3), 32'h0), "hold_acc");
        ex_ready = 0; set_id(5'd3, 1, 5'd3, 1, 32'h404);
        wbv = 1; wb_wen = 1; wb_rd = 5'd3; wb_ok = 1; wb_d = 32'h999;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold/ready", 160'(ready), 160'(1'b0));
            cycle(0, '0, "hold");
        end
        ex_ready = 1;
        #1 check("release/ready", 160'(ready), 160'(1'b1));
        cycle(1, mk(32'h999, 32'h999), "release");
        id_valid = 0;
        cycle(0, '0, "drain");

        // flush blocks acceptance
        clr_src(); set_id(5'd1, 1, 5'd2, 1, 32'h500); flush = 1;
        #1 check("flush/ready", 160'(ready), 160'(1'b0));
        cycle(0, '0, "flush");
        flush = 0;
        cycle(1, mk(rf(1), rf(2)), "pre_rst");
        ex_ready = 0; rst = 1;
        #1 check("rst_hold/ready", 160'(ready), 160'(1'b0));
        cycle(0, '0, "rst_hold");
        check("rst_hold/payload_zero", 160'(obs), 160'(0));
        rst = 0; ex_ready = 1;

        // no-forwarding variant stalls on any match, then reads the regfile
        set_id(5'd3, 1, 5'd10, 1, 32'h600);
        wbv = 1; wb_wen = 1; wb_rd = 5'd3; wb_ok = 1; wb_d = 32'h333;
        #1 check("nofwd/ready0", 160'(ready0), 160'(1'b0));
        check("nofwd/ready", 160'(ready), 160'(1'b1));
        cycle(1, mk(32'h333, rf(10)), "nofwd_fwdside");
        check("nofwd/valid0", 160'(o_valid0), 160'(1'b0));
        clr_src(); pc = 32'h604;
        #1 check("nofwd/ready1", 160'(ready0), 160'(1'b1));
        cycle(1, mk(rf(3), rf(10)), "nofwd_clear");
        check("nofwd/valid1", 160'(o_valid0), 160'(1'b1));
        check("nofwd/payload", 160'(obs0), 160'(mk(rf(3), rf(10))));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_operand_stage.md
ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

Interface
REQ-001 SHALL have parameter FWD_EN, default 1, meaning 1 = bypass from EX/MEM/WB, 0 = stall on any RAW match.
REQ-002 SHALL have i_clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have decode inputs: i_id_valid 1, i_id_rs1_addr/i_id_rs2_addr REGIDX_WIDTH, i_id_rs1_used/i_id_rs2_used 1, i_id_rd_addr REGIDX_WIDTH, i_id_rd_wen 1, i_id_is_load 1, i_id_pc 32, i_id_imm 32, i_id_ctrl CTRL_WIDTH.
REQ-005 SHALL have o_id_ready  output  1  decode instruction accepted this cycle when high with i_id_valid.
REQ-006 SHALL have o_rf_rs1_addr/o_rf_rs2_addr  output  REGIDX_WIDTH  regfile read addresses (combinational copy of i_id_rs*_addr); i_rf_rs1_data/i_rf_rs2_data  input  32  regfile read data (combinational, no internal write bypass).
REQ-007 SHALL have, per source S in {ex, mem, wb}: i_S_valid 1, i_S_rd_wen 1, i_S_rd_addr REGIDX_WIDTH, i_S_data_ok 1 (result available now), i_S_rd_data 32.
REQ-008 SHALL have i_flush  input  1  kill ID/EX contents; i_ex_ready  input  1  EX accepts current o_ex_*.
REQ-009 SHALL have outputs o_ex_valid 1, o_ex_rs1_data/o_ex_rs2_data 32, o_ex_rd_addr REGIDX_WIDTH, o_ex_rd_wen 1, o_ex_is_load 1, o_ex_pc 32, o_ex_imm 32, o_ex_ctrl CTRL_WIDTH (all registered).

Function
REQ-010 Source S SHALL match rsN when i_S_valid & i_S_rd_wen & i_S_rd_addr==rsN & rsN!=0 & i_id_rsN_used.
REQ-011 Operand selection SHALL use priority ex > mem > wb > regfile; only the highest-priority match is considered.
REQ-012 Address 0 SHALL always yield operand 32'h0, never forwarded, never hazarding.
REQ-013 Hazard SHALL assert when i_id_valid and, for either used operand, the selected match has i_S_data_ok=0, or (FWD_EN=0) any match exists.
REQ-014 o_id_ready SHALL equal ~i_flush & ~hazard & (~o_ex_valid | i_ex_ready); purely combinational.
REQ-015 Accept (i_id_valid & o_id_ready): next cycle o_ex_valid=1, o_ex_* = decode fields plus selected operands.
REQ-016 Advance without accept (~o_ex_valid | i_ex_ready, no accept, no flush): next cycle o_ex_valid=0 (bubble); payload don't-care.
REQ-017 Hold (o_ex_valid & ~i_ex_ready, no flush): all o_ex_* unchanged, including operands, regardless of later WB writes.
REQ-018 i_flush SHALL force o_ex_valid=0 next cycle, overriding accept and hold.
REQ-019 Latency SHALL be exactly 1 cycle from accept to o_ex_valid; throughput 1 instruction/cycle without hazards.
REQ-020 Decode SHALL hold i_id_* stable while i_id_valid & ~o_id_ready; block relies on this, no input skid.
REQ-021 Load in EX (i_ex_data_ok=0) matching a used operand SHALL stall exactly until the load's source reports data_ok, then forward from that source.

Reset
REQ-022 On i_rst, next cycle o_ex_valid=0 and all o_ex_* payload = 0; reset overrides flush, accept and hold.
REQ-023 During i_rst, o_id_ready SHALL be 0; reset mid-hold discards the held instruction.

Structure
REQ-024 REGIDX_WIDTH, CTRL_WIDTH and the ID/EX payload struct SHALL live in rv32i_pkg.
REQ-025 One sub-module, operand_bypass (per-operand match/priority/select/need-stall), SHALL be instantiated twice (rs1, rs2).
REQ-026 No storage other than the ID/EX register; no latches.

Verification
REQ-027 rs1=5 used, i_ex rd=5 data_ok=1 data=32'hDEAD_BEEF, mem rd=5 data=1 -> o_ex_rs1_data=32'hDEAD_BEEF next cycle.
REQ-028 rs2=0, all sources rd=0 wen=1 data=32'hFFFF_FFFF -> o_ex_rs2_data=0, o_id_ready=1.
REQ-029 rs1=7, ex load rd=7 data_ok=0 one cycle, then mem rd=7 data_ok=1 data=32'h1234 -> o_id_ready 0 then 1; one bubble (o_ex_valid=0), then o_ex_rs1_data=32'h1234.
REQ-030 o_ex_valid=1, i_ex_ready=0 for 3 cycles, wb writes rd=rs of held instr -> o_ex_* unchanged 3 cycles, o_id_ready=0.
REQ-031 Accept and i_flush same cycle -> o_ex_valid=0 next cycle; i_rst during hold -> o_ex_valid=0, payload 0.
REQ-032 FWD_EN=0, wb match rd=3 data_ok=1 -> stall while match present; regfile value used once wb clears.
